// File: rtl/multiport_regfile.sv
// Multi-port general-purpose register file for the pipelined RV32I core.
// Register 0 is hardwired to zero. Reads are combinational, with optional
// same-cycle bypass of write data. A per-register busy scoreboard tracks
// pending writers: issue marks a register busy and writeback clears it.
module multiport_regfile #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int BYPASS  = 1,
  parameter int DBG_REG = 10,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREGS-1:0]     busy_vec,
  output logic [XLEN-1:0]      dbg_data
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0][XLEN-1:0] wr_val;
  logic [NREGS-1:0]           wr_hit;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index port wins on an address conflict. Register 0 never hits.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: a new producer (issue) wins over a retiring one.
  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_valid && (iss_rd == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else begin
        busy_nxt[r] = busy[r] & ~wr_hit[r];
      end
    end
  end

  // Register storage; entry 0 is only ever loaded by reset, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
    end
  end

  // Busy scoreboard register; reset drops any in-flight hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports. With bypass, a same-cycle write supplies the data and also
  // releases the hazard, since the consumer already sees the new value.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          if (wr_hit[rd_addr[i*AW +: AW]]) begin
            rd_data[i*XLEN +: XLEN] = wr_val[rd_addr[i*AW +: AW]];
          end
          rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~wr_hit[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  assign busy_vec = busy;
  assign dbg_data = regs[DBG_REG];

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: one bypassing instance and one
// committed-state-only instance share the same stimulus.
module tb_multiport_regfile;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [31:0] busy_vec, busy_vec_nb;
  logic [31:0] dbg_data, dbg_data_nb;

  int checks = 0;
  int errors = 0;

  multiport_regfile #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(busy_vec), .dbg_data(dbg_data)
  );

  multiport_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_vec(busy_vec_nb), .dbg_data(dbg_data_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [31:0] d1, input logic [31:0] d0);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic idle();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_x0();
    step();
    drive_wr(2'b01, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF);
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    rd_addr   = {5'd0, 5'd0};
    #2;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd_data); end
    step();
    idle();
    #2;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rd_data); end
    checks++; if (rd_data_nb !== 64'h0) begin errors++; $display("FAIL x0_read_nb got=%h exp=0", rd_data_nb); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_basic();
    step();
    drive_wr(2'b01, 5'd0, 5'd5, 32'h0, 32'h12345678);
    rd_addr = {5'd0, 5'd0};
    step();
    idle();
    rd_addr = {5'd5, 5'd5};
    #2;
    checks++; if (rd_data !== 64'h12345678_12345678) begin errors++; $display("FAIL basic_x5 got=%h exp=%h", rd_data, 64'h12345678_12345678); end
    checks++; if (rd_data_nb !== 64'h12345678_12345678) begin errors++; $display("FAIL basic_x5_nb got=%h exp=%h", rd_data_nb, 64'h12345678_12345678); end
    step();
    drive_wr(2'b01, 5'd0, 5'd10, 32'h0, 32'h00000042);
    rd_addr = {5'd0, 5'd10};
    #2;
    checks++; if (rd_data !== 64'h00000000_00000042) begin errors++; $display("FAIL basic_x10_bypass got=%h exp=42", rd_data); end
    checks++; if (rd_data_nb !== 64'h0) begin errors++; $display("FAIL basic_x10_nobypass got=%h exp=0", rd_data_nb); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL basic_dbg_before got=%h exp=0", dbg_data); end
    step();
    idle();
    checks++; if (dbg_data !== 32'h42) begin errors++; $display("FAIL basic_dbg_after got=%h exp=42", dbg_data); end
    checks++; if (dbg_data_nb !== 32'h42) begin errors++; $display("FAIL basic_dbg_after_nb got=%h exp=42", dbg_data_nb); end
  endtask

  task automatic test_conflict();
    step();
    drive_wr(2'b11, 5'd7, 5'd7, 32'h2222, 32'h1111);
    rd_addr = {5'd7, 5'd7};
    #2;
    checks++; if (rd_data !== 64'h00002222_00002222) begin errors++; $display("FAIL conflict_bypass got=%h exp=2222 on both", rd_data); end
    step();
    idle();
    #2;
    checks++; if (rd_data_nb !== 64'h00002222_00002222) begin errors++; $display("FAIL conflict_x7 got=%h exp=2222 on both", rd_data_nb); end
    step();
    drive_wr(2'b11, 5'd4, 5'd3, 32'h44, 32'h33);
    step();
    idle();
    rd_addr = {5'd4, 5'd3};
    #2;
    checks++; if (rd_data_nb !== 64'h00000044_00000033) begin errors++; $display("FAIL conflict_distinct got=%h exp=%h", rd_data_nb, 64'h00000044_00000033); end
  endtask

  task automatic test_bypass();
    step();
    drive_wr(2'b01, 5'd0, 5'd9, 32'h0, 32'h5);
    step();
    drive_wr(2'b10, 5'd9, 5'd0, 32'h9, 32'h0);
    rd_addr = {5'd9, 5'd9};
    #2;
    checks++; if (rd_data !== 64'h00000009_00000009) begin errors++; $display("FAIL bypass_on got=%h exp=9 on both", rd_data); end
    checks++; if (rd_data_nb !== 64'h00000005_00000005) begin errors++; $display("FAIL bypass_off got=%h exp=5 on both", rd_data_nb); end
    checks++; if (dbg_data !== 32'h42) begin errors++; $display("FAIL bypass_dbg got=%h exp=42", dbg_data); end
    step();
    idle();
    #2;
    checks++; if (rd_data_nb !== 64'h00000009_00000009) begin errors++; $display("FAIL bypass_off_next got=%h exp=9 on both", rd_data_nb); end
  endtask

  task automatic test_scoreboard();
    step();
    iss_valid = 1'b1;
    iss_rd    = 5'd12;
    rd_addr   = {5'd12, 5'd12};
    #2;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_issue_cycle got=%h exp=0", busy_vec); end
    step();
    idle();
    #2;
    checks++; if (busy_vec !== 32'h00001000) begin errors++; $display("FAIL sb_busy_set got=%h exp=00001000", busy_vec); end
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_rd_busy got=%b exp=11", rd_busy); end
    checks++; if (rd_busy_nb !== 2'b11) begin errors++; $display("FAIL sb_rd_busy_nb got=%b exp=11", rd_busy_nb); end
    step();
    drive_wr(2'b10, 5'd12, 5'd0, 32'hABC, 32'h0);
    #2;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_release_bypass got=%b exp=00", rd_busy); end
    checks++; if (rd_busy_nb !== 2'b11) begin errors++; $display("FAIL sb_hold_nobypass got=%b exp=11", rd_busy_nb); end
    checks++; if (busy_vec !== 32'h00001000) begin errors++; $display("FAIL sb_vec_write_cycle got=%h exp=00001000", busy_vec); end
    checks++; if (rd_data !== 64'h00000ABC_00000ABC) begin errors++; $display("FAIL sb_bypass_data got=%h exp=abc on both", rd_data); end
    step();
    idle();
    #2;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_cleared got=%h exp=0", busy_vec); end
    checks++; if (rd_busy_nb !== 2'b00) begin errors++; $display("FAIL sb_cleared_rd_busy_nb got=%b exp=00", rd_busy_nb); end
  endtask

  task automatic test_collision();
    step();
    iss_valid = 1'b1;
    iss_rd    = 5'd12;
    rd_addr   = {5'd12, 5'd12};
    step();
    idle();
    drive_wr(2'b01, 5'd0, 5'd12, 32'h0, 32'h5A5A);
    iss_valid = 1'b1;
    iss_rd    = 5'd12;
    #2;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL coll_rd_busy_cycle got=%b exp=00", rd_busy); end
    checks++; if (rd_busy_nb !== 2'b11) begin errors++; $display("FAIL coll_rd_busy_cycle_nb got=%b exp=11", rd_busy_nb); end
    step();
    idle();
    #2;
    checks++; if (busy_vec !== 32'h00001000) begin errors++; $display("FAIL coll_busy_kept got=%h exp=00001000", busy_vec); end
    checks++; if (busy_vec_nb !== 32'h00001000) begin errors++; $display("FAIL coll_busy_kept_nb got=%h exp=00001000", busy_vec_nb); end
    checks++; if (rd_data_nb !== 64'h00005A5A_00005A5A) begin errors++; $display("FAIL coll_data got=%h exp=5a5a on both", rd_data_nb); end
    checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL coll_rd_busy_after got=%b exp=11", rd_busy); end
  endtask

  task automatic test_reset_midrun();
    step();
    rd_addr = {5'd7, 5'd5};
    #2;
    checks++; if (rd_data_nb !== 64'h00002222_12345678) begin errors++; $display("FAIL midrst_pre got=%h exp=%h", rd_data_nb, 64'h00002222_12345678); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_data_nb !== 64'h0) begin errors++; $display("FAIL midrst_rd_data_nb got=%h exp=0", rd_data_nb); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL midrst_busy got=%h exp=0", busy_vec); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL midrst_dbg got=%h exp=0", dbg_data); end
    drive_wr(2'b01, 5'd0, 5'd6, 32'h0, 32'h66);
    iss_valid = 1'b1;
    iss_rd    = 5'd6;
    step();
    idle();
    rst = 1'b0;
    rd_addr = {5'd6, 5'd6};
    #2;
    checks++; if (rd_data_nb !== 64'h0) begin errors++; $display("FAIL midrst_write_ignored got=%h exp=0", rd_data_nb); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL midrst_issue_ignored got=%h exp=0", busy_vec); end
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    test_reset();
    test_x0();
    test_basic();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
